// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, state encoding and stall-merge helper
// for the pipeline stall/flush scheduler.
package pipeline_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Bit order: [0]pc [1]if_id [2]id_ex [3]exe_mem [4]mem_wb [5]rsvd
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        CTRL_RUN   = 2'd0,
        CTRL_PEND  = 2'd1,
        CTRL_FLUSH = 2'd2
    } ctrl_state_t;

    // Later stages win: a stall in a later stage must
    // freeze every earlier stage as well.
    function automatic logic [5:0] stall_merge(
        input logic mem,
        input logic ex,
        input logic id,
        input logic fe
    );
        logic [5:0] v;
        v = STALL_NONE;
        priority case (1'b1)
            mem:     v = STALL_MEM;
            ex:      v = STALL_EX;
            id:      v = STALL_ID;
            fe:      v = STALL_IF;
            default: v = STALL_NONE;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and
// latches a sticky timeout flag until reset.
// Ports: clk, reset, stalled, flush in; timeout out.
module stall_watchdog #(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic stalled,
    input  logic flush,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT =
        CNT_W'(STALL_TIMEOUT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             flag;

    // Saturate rather than wrap so a very long stall
    // cannot make the count look short again.
    always_comb begin
        cnt_n = cnt;
        if (!stalled || flush) begin
            cnt_n = '0;
        end else if (cnt != LIMIT) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            cnt <= cnt_n;
            if (cnt_n == LIMIT) begin
                flag <= 1'b1;
            end
        end
    end

    assign timeout = flag;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline.
// Ports: clk, reset, i_stallreq_{if,id,ex,mem}, i_excp_valid,
//   i_excp_eret, i_excp_vector, i_epc in; o_stall[5:0],
//   o_flush, o_new_pc[31:0], o_stall_timeout out.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_stallreq_if,
    input  logic        i_stallreq_id,
    input  logic        i_stallreq_ex,
    input  logic        i_stallreq_mem,
    input  logic        i_excp_valid,
    input  logic        i_excp_eret,
    input  logic [31:0] i_excp_vector,
    input  logic [31:0] i_epc,
    output logic [5:0]  o_stall,
    output logic        o_flush,
    output logic [31:0] o_new_pc,
    output logic        o_stall_timeout
);

    ctrl_state_t state;
    ctrl_state_t state_n;

    logic [31:0] tgt_q;
    logic [31:0] tgt_n;
    logic [31:0] pc_q;
    logic [31:0] pc_n;
    logic [31:0] excp_tgt;
    logic [5:0]  req_vec;

    assign excp_tgt = i_excp_eret ? i_epc : i_excp_vector;

    assign req_vec = stall_merge(
        i_stallreq_mem,
        i_stallreq_ex,
        i_stallreq_id,
        i_stallreq_if
    );

    // The redirect pc register only loads on entry to
    // FLUSH, so it holds its last value otherwise.
    always_comb begin
        state_n = state;
        tgt_n   = tgt_q;
        pc_n    = pc_q;
        unique case (state)
            CTRL_RUN: begin
                if (i_excp_valid) begin
                    tgt_n = excp_tgt;
                    if (i_stallreq_mem) begin
                        state_n = CTRL_PEND;
                    end else begin
                        state_n = CTRL_FLUSH;
                        pc_n    = excp_tgt;
                    end
                end
            end
            CTRL_PEND: begin
                if (!i_stallreq_mem) begin
                    state_n = CTRL_FLUSH;
                    pc_n    = tgt_q;
                end
            end
            CTRL_FLUSH: begin
                state_n = CTRL_RUN;
            end
            default: begin
                state_n = CTRL_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CTRL_RUN;
            tgt_q <= ZERO_WORD;
            pc_q  <= ZERO_WORD;
        end else begin
            state <= state_n;
            tgt_q <= tgt_n;
            pc_q  <= pc_n;
        end
    end

    // Requests are masked while flushing so the cleared
    // registers load the redirected stream.
    assign o_flush  = (state == CTRL_FLUSH);
    assign o_stall  = o_flush ? STALL_NONE : req_vec;
    assign o_new_pc = pc_q;

    stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT),
        .CNT_W         (CNT_W)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .stalled (o_stall != STALL_NONE),
        .flush   (o_flush),
        .timeout (o_stall_timeout)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed cases
// followed by random traffic against a behavioural model.
module tb_pipeline_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_if, r_id, r_ex, r_mem;
    logic        ev, er;
    logic [31:0] vec, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] pend_q[$];
    bit          m_flush;
    logic [31:0] m_pc;
    int          m_run;
    bit          m_flag;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .STALL_TIMEOUT (T),
        .CNT_W         (4)
    ) dut (
        .clk             (clk),
        .reset           (rst),
        .i_stallreq_if   (r_if),
        .i_stallreq_id   (r_id),
        .i_stallreq_ex   (r_ex),
        .i_stallreq_mem  (r_mem),
        .i_excp_valid    (ev),
        .i_excp_eret     (er),
        .i_excp_vector   (vec),
        .i_epc           (epc),
        .o_stall         (stall),
        .o_flush         (flush),
        .o_new_pc        (new_pc),
        .o_stall_timeout (tmo)
    );

    // Stall depth = number of frozen stages incl. pc.
    function automatic logic [5:0] exp_stall();
        int n;
        logic [6:0] one;
        n = 0;
        if (m_flush)    n = 0;
        else if (r_mem) n = 5;
        else if (r_ex)  n = 4;
        else if (r_id)  n = 3;
        else if (r_if)  n = 2;
        one = 7'd1;
        return 6'((one << n) - 7'd1);
    endfunction

    task automatic model_reset();
        pend_q.delete();
        m_flush = 1'b0;
        m_pc    = 32'h0;
        m_run   = 0;
        m_flag  = 1'b0;
    endtask

    task automatic model_clock();
        bit nf;
        logic [31:0] t;
        if (rst) begin
            model_reset();
        end else begin
            if (exp_stall() != 6'd0 && !m_flush)
                m_run = m_run + 1;
            else
                m_run = 0;
            if (m_run >= T) m_flag = 1'b1;
            nf = 1'b0;
            if (m_flush) begin
                nf = 1'b0;
            end else if (pend_q.size() != 0) begin
                if (!r_mem) begin
                    m_pc = pend_q.pop_front();
                    nf = 1'b1;
                end
            end else if (ev) begin
                t = er ? epc : vec;
                if (r_mem) pend_q.push_back(t);
                else begin
                    m_pc = t;
                    nf = 1'b1;
                end
            end
            m_flush = nf;
        end
    endtask

    task automatic step(
        input logic        r,
        input logic        m,
        input logic        x,
        input logic        d,
        input logic        f,
        input logic        e,
        input logic        et,
        input logic [31:0] v,
        input logic [31:0] p
    );
        logic [5:0] es;
        @(negedge clk);
        rst = r; r_mem = m; r_ex = x;
        r_id = d; r_if = f; ev = e;
        er = et; vec = v; epc = p;
        #1;
        es = exp_stall();
        checks++;
        assert (stall === es) else begin
            errors++;
            $error("FAIL stall got=%b exp=%b", stall, es);
        end
        checks++;
        assert (flush === m_flush) else begin
            errors++;
            $error("FAIL flush got=%b exp=%b", flush, m_flush);
        end
        checks++;
        assert (new_pc === m_pc) else begin
            errors++;
            $error("FAIL new_pc got=%h exp=%h", new_pc, m_pc);
        end
        checks++;
        assert (tmo === m_flag) else begin
            errors++;
            $error("FAIL timeout got=%b exp=%b", tmo, m_flag);
        end
        @(posedge clk);
        model_clock();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] rv;
        rst = 1'b1; r_if = 0; r_id = 0; r_ex = 0;
        r_mem = 0; ev = 0; er = 0; vec = 0; epc = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(1);

        // Priority
        step(0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        checks++;
        assert (stall === 6'b001111) else begin
            errors++;
            $error("FAIL prio_idex got=%b exp=001111", stall);
        end
        step(0, 1, 1, 1, 0, 0, 0, 32'h0, 32'h0);
        checks++;
        assert (stall === 6'b011111) else begin
            errors++;
            $error("FAIL prio_mem got=%b exp=011111", stall);
        end
        idle(1);

        // Clean exception
        step(0, 0, 0, 0, 0, 1, 0, 32'hBFC00380, 32'h0);
        idle(1);
        checks++;
        assert (flush === 1'b1 && new_pc === 32'hBFC00380)
        else begin
            errors++;
            $error("FAIL excp_clean got=%b/%h exp=1/bfc00380",
                   flush, new_pc);
        end
        idle(2);

        // Exception under mem stall
        step(0, 1, 0, 0, 0, 1, 0, 32'h80000180, 32'h0);
        step(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 1, 0, 1, 0, 32'h12345678, 32'h0);
        checks++;
        assert (stall === 6'b011111 && flush === 1'b0)
        else begin
            errors++;
            $error("FAIL pend_hold got=%b/%b exp=011111/0",
                   stall, flush);
        end
        step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(2);

        // Eret
        step(0, 0, 0, 0, 0, 1, 1, 32'hBFC00380, 32'h80001234);
        idle(1);
        checks++;
        assert (new_pc === 32'h80001234) else begin
            errors++;
            $error("FAIL eret got=%h exp=80001234", new_pc);
        end
        idle(2);

        // Watchdog
        for (int i = 0; i < T - 1; i++)
            step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(1);
        checks++;
        assert (tmo === 1'b0) else begin
            errors++;
            $error("FAIL wdog_short got=%b exp=0", tmo);
        end
        for (int i = 0; i < T; i++)
            step(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(3);
        checks++;
        assert (tmo === 1'b1) else begin
            errors++;
            $error("FAIL wdog_sticky got=%b exp=1", tmo);
        end
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(1);

        // Reset during PEND
        step(0, 1, 0, 0, 0, 1, 0, 32'hDEADBEE0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(3);
        checks++;
        assert (flush === 1'b0 && new_pc === 32'h0)
        else begin
            errors++;
            $error("FAIL rst_pend got=%b/%h exp=0/0",
                   flush, new_pc);
        end

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rv = $urandom;
            step(rv[7:0] == 8'd0,
                 rv[10:8] == 3'd0,
                 rv[13:11] == 3'd0,
                 rv[16:14] == 3'd0,
                 rv[19:17] == 3'd0,
                 rv[22:20] == 3'd0,
                 rv[23],
                 $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
